// File: rtl/fdiv_arb_if.sv
// fdiv_arb_if: requester-side and fdiv-side signals of the fdiv_arb scheduler.
// The slave modport is the arbiter's view. The master modport is the environment's view:
// the two requesters plus the fdiv unit.
interface fdiv_arb_if;
  // requester 0 / requester 1
  logic        req0;
  logic        req1;
  logic [30:0] dvd0;
  logic [30:0] dvd1;
  logic [30:0] dvs0;
  logic [30:0] dvs1;
  logic        ack0;
  logic        ack1;

  // result and status
  logic [30:0] res;
  logic        ovf;
  logic        err;
  logic        busy;
  logic        owner;

  // fdiv unit
  logic        div_start;
  logic [30:0] div_dividend;
  logic [30:0] div_divisor;
  logic        div_stop;
  logic [30:0] div_out;
  logic        div_overflow;

  modport slave (
    input  req0, req1, dvd0, dvd1, dvs0, dvs1,
    input  div_stop, div_out, div_overflow,
    output ack0, ack1, res, ovf, err, busy, owner,
    output div_start, div_dividend, div_divisor
  );

  modport master (
    output req0, req1, dvd0, dvd1, dvs0, dvs1,
    output div_stop, div_out, div_overflow,
    input  ack0, ack1, res, ovf, err, busy, owner,
    input  div_start, div_dividend, div_divisor
  );
endinterface

// File: rtl/fdiv_arb.sv
// fdiv_arb: round-robin scheduler sharing one fdiv unit between two requesters.
// It latches the winner's operands and presents the dividend on the start cycle and the
// divisor on the following cycle. It captures the quotient on stop and acknowledges for
// one cycle. A watchdog aborts a unit that never raises stop.
module fdiv_arb #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  fdiv_arb_if.slave  bus
);

  localparam int unsigned     WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_FEED,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [30:0]     opd;
  logic [30:0]     ops;
  logic [30:0]     res_q;
  logic            ovf_q;
  logic            err_q;
  logic            owner_q;
  logic            prio_q;
  logic [WD_W-1:0] wd;

  logic            grant;
  logic            grant_idx;
  logic            cap_stop;
  logic            cap_to;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic with grant, capture and abort decode.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_idx = 1'b0;
    cap_stop  = 1'b0;
    cap_to    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant     = 1'b1;
          // On a tie, the requester that was not served last wins.
          grant_idx = (bus.req0 && bus.req1) ? ~prio_q : bus.req1;
          state_nxt = S_START;
        end
      end
      S_START: state_nxt = S_FEED;
      S_FEED:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.div_stop) begin
          cap_stop  = 1'b1;
          state_nxt = S_DONE;
        end else if (wd == WD_LAST) begin
          cap_to    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand latches and owner, loaded only on a grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opd     <= '0;
      ops     <= '0;
      owner_q <= 1'b0;
    end else if (grant) begin
      owner_q <= grant_idx;
      opd     <= grant_idx ? bus.dvd1 : bus.dvd0;
      ops     <= grant_idx ? bus.dvs1 : bus.dvs0;
    end
  end

  // Round-robin pointer, updated to the owner on each entry to DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_q <= 1'b1;
    end else if (cap_stop || cap_to) begin
      prio_q <= owner_q;
    end
  end

  // Watchdog cleared in FEED and counting WAIT cycles. It leaves WAIT at WD_LAST, so it never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd <= '0;
    end else if (state == S_FEED) begin
      wd <= '0;
    end else if ((state == S_WAIT) && !cap_stop && !cap_to) begin
      wd <= wd + WD_W'(1);
    end
  end

  // Result registers, written only when WAIT ends and held until the next capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else if (cap_stop) begin
      res_q <= bus.div_out;
      ovf_q <= bus.div_overflow;
      err_q <= 1'b0;
    end else if (cap_to) begin
      res_q <= '0;
      ovf_q <= 1'b1;
      err_q <= 1'b1;
    end
  end

  assign bus.ack0         = (state == S_DONE) && !owner_q;
  assign bus.ack1         = (state == S_DONE) &&  owner_q;
  assign bus.busy         = (state != S_IDLE);
  assign bus.owner        = owner_q;
  assign bus.res          = res_q;
  assign bus.ovf          = ovf_q;
  assign bus.err          = err_q;
  assign bus.div_start    = (state == S_START);
  assign bus.div_dividend = opd;
  assign bus.div_divisor  = ops;

endmodule

// File: tb/tb_fdiv_arb.sv
// tb_fdiv_arb: directed and randomized checks of fdiv_arb against a cycle-level fdiv stub
// and a transaction-level reference model (grant order, ack latency, result tuple).
module tb_fdiv_arb;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fdiv_arb_if bus ();

  fdiv_arb #(.TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int m_prio = 1;

  // fdiv stub state
  bit          st_on   = 0;
  int          st_n    = 0;
  int          st_lat  = 10;
  bit          st_hang = 0;
  bit          st_fix  = 0;
  logic [30:0] st_fix_val = '0;
  logic [30:0] st_dvd = '0;
  logic [30:0] st_dvs = '0;
  bit          stray  = 0;

  function automatic logic [30:0] quot(input logic [30:0] a, input logic [30:0] b);
    return a ^ {b[14:0], b[30:15]};
  endfunction

  function automatic logic dz(input logic [30:0] b);
    return (b[29:0] == 30'h0);
  endfunction

  // Advance one clock and land 1 time unit after the edge. The stub samples the dividend in
  // the start cycle and the divisor in the next one. It raises stop st_lat cycles after start.
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.div_start) begin
      st_on  = 1;
      st_n   = 0;
      st_dvd = bus.div_dividend;
    end else if (st_on) begin
      st_n++;
      if (st_n == 1) st_dvs = bus.div_divisor;
    end
    bus.div_stop     = 1'b0;
    bus.div_out      = 31'($urandom);
    bus.div_overflow = 1'($urandom);
    if (stray) begin
      bus.div_stop     = 1'b1;
      bus.div_out      = 31'h7fffffff;
      bus.div_overflow = 1'b1;
      stray            = 0;
    end else if (st_on && !st_hang && st_n > 0 && st_n == st_lat) begin
      bus.div_stop     = 1'b1;
      bus.div_out      = st_fix ? st_fix_val : quot(st_dvd, st_dvs);
      bus.div_overflow = st_fix ? 1'b0 : dz(st_dvs);
      st_on            = 0;
    end
  endtask

  // Runs one transaction from cycle 0 (the caller is in IDLE with requests set) until an ack.
  // It records the observations, and the served requester drops req.
  // ack_cyc is -1 if no ack arrives within the budget.
  task automatic serve(output int ack_cyc, output int a0, output int a1,
                       output int sn, output int sc,
                       output logic [30:0] r, output logic o, output logic e, output logic ow);
    ack_cyc = -1; a0 = 0; a1 = 0; sn = 0; sc = -1; r = '0; o = 0; e = 0; ow = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (bus.div_start) begin
        sn++;
        if (sc < 0) sc = k;
      end
      if (bus.ack0) a0++;
      if (bus.ack1) a1++;
      if (bus.ack0 || bus.ack1) begin
        ack_cyc = k;
        r  = bus.res;
        o  = bus.ovf;
        e  = bus.err;
        ow = bus.owner;
        if (bus.ack0) bus.req0 = 1'b0;
        if (bus.ack1) bus.req1 = 1'b0;
        return;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.req0 = 0; bus.req1 = 0;
    st_on = 0; st_hang = 0; st_fix = 0; stray = 0;
    step();
    step();
    reset_n = 1'b1;
    m_prio  = 1;
  endtask

  task automatic test_reset();
    logic [130:0] outs;
    reset_n = 1'b0;
    step();
    step();
    outs = {bus.ack0, bus.ack1, bus.ovf, bus.err, bus.busy, bus.owner, bus.div_start,
            bus.res, bus.div_dividend, bus.div_divisor, bus.ovf, bus.err, bus.busy};
    n_cmp++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", outs);
    end
    reset_n = 1'b1;
    m_prio  = 1;
    step();
    n_cmp++;
    if ({bus.busy, bus.div_start} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release_idle: busy/div_start got %b want 00", {bus.busy, bus.div_start});
    end
  endtask

  task automatic test_single();
    int ac, a0, a1, sn, sc;
    logic [30:0] r;
    logic o, e, ow;
    st_fix = 1; st_fix_val = 31'h21080000; st_lat = 10;
    bus.dvd0 = 31'h21080000; bus.dvs0 = 31'h21040000; bus.req0 = 1;
    serve(ac, a0, a1, sn, sc, r, o, e, ow);
    n_cmp++;
    if (sn !== 1 || sc !== 1) begin
      n_fail++;
      $display("FAIL single_start: count %0d first %0d want 1/1", sn, sc);
    end
    n_cmp++;
    if (ac !== 12 || a0 !== 1 || a1 !== 0) begin
      n_fail++;
      $display("FAIL single_ack: cycle %0d ack0 %0d ack1 %0d want 12/1/0", ac, a0, a1);
    end
    n_cmp++;
    if ({r, o, e, ow} !== {31'h21080000, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL single_result: res %h ovf %b err %b owner %b want 21080000/0/0/0", r, o, e, ow);
    end
    n_cmp++;
    if (st_dvd !== 31'h21080000 || st_dvs !== 31'h21040000) begin
      n_fail++;
      $display("FAIL single_feed: dividend %h divisor %h want 21080000/21040000", st_dvd, st_dvs);
    end
    m_prio = 0;
    st_fix = 0;
    step();
    n_cmp++;
    if ({bus.ack0, bus.ack1, bus.busy} !== 3'b000 || bus.res !== 31'h21080000) begin
      n_fail++;
      $display("FAIL single_after: ack0/ack1/busy %b res %h want 000/21080000",
               {bus.ack0, bus.ack1, bus.busy}, bus.res);
    end
  endtask

  task automatic test_tie();
    int ac, a0, a1, sn, sc;
    logic [30:0] r;
    logic o, e, ow;
    logic [30:0] d1, s1;
    do_reset();
    st_lat = 10;
    d1 = 31'($urandom); s1 = 31'h12345678;
    bus.dvd0 = 31'($urandom); bus.dvs0 = 31'h21040000; bus.dvd1 = d1; bus.dvs1 = s1;
    bus.req0 = 1; bus.req1 = 1;
    serve(ac, a0, a1, sn, sc, r, o, e, ow);
    n_cmp++;
    if (ac !== 12 || a0 !== 1 || ow !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_first: cycle %0d ack0 %0d owner %b want 12/1/0", ac, a0, ow);
    end
    step();
    serve(ac, a0, a1, sn, sc, r, o, e, ow);
    n_cmp++;
    if (ac + 13 !== 25 || a1 !== 1 || ow !== 1'b1) begin
      n_fail++;
      $display("FAIL tie_second: cycle %0d ack1 %0d owner %b want 25/1/1", ac + 13, a1, ow);
    end
    n_cmp++;
    if (r !== quot(d1, s1) || o !== dz(s1) || e !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_second_res: res %h ovf %b want %h/%b", r, o, quot(d1, s1), dz(s1));
    end
    step();
    bus.req0 = 1; bus.req1 = 1;
    serve(ac, a0, a1, sn, sc, r, o, e, ow);
    n_cmp++;
    if (a0 !== 1 || a1 !== 0 || ac !== 12) begin
      n_fail++;
      $display("FAIL tie_rearm: ack0 %0d ack1 %0d cycle %0d want 1/0/12", a0, a1, ac);
    end
    step();
    serve(ac, a0, a1, sn, sc, r, o, e, ow);
    m_prio = 1;
    step();
  endtask

  task automatic test_divzero();
    int ac, a0, a1, sn, sc;
    logic [30:0] r;
    logic o, e, ow;
    logic [30:0] d;
    d = 31'h21080000;
    st_lat = 6;
    bus.dvd1 = d; bus.dvs1 = 31'h0; bus.req1 = 1;
    serve(ac, a0, a1, sn, sc, r, o, e, ow);
    n_cmp++;
    if (a1 !== 1 || a0 !== 0 || ac !== 8) begin
      n_fail++;
      $display("FAIL divzero_ack: ack1 %0d ack0 %0d cycle %0d want 1/0/8", a1, a0, ac);
    end
    n_cmp++;
    if (o !== 1'b1 || e !== 1'b0 || r !== quot(d, 31'h0)) begin
      n_fail++;
      $display("FAIL divzero_flags: ovf %b err %b res %h want 1/0/%h", o, e, r, quot(d, 31'h0));
    end
    m_prio = 1;
    step();
  endtask

  task automatic test_watchdog();
    int ac, a0, a1, sn, sc;
    logic [30:0] r;
    logic o, e, ow;
    st_hang = 1;
    bus.dvd0 = 31'($urandom); bus.dvs0 = 31'($urandom); bus.req0 = 1;
    serve(ac, a0, a1, sn, sc, r, o, e, ow);
    n_cmp++;
    if (ac !== TO + 3 || a0 !== 1) begin
      n_fail++;
      $display("FAIL watchdog_ack: cycle %0d ack0 %0d want %0d/1", ac, a0, TO + 3);
    end
    n_cmp++;
    if ({r, o, e} !== {31'h0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL watchdog_result: res %h ovf %b err %b want 0/1/1", r, o, e);
    end
    step();
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL watchdog_busy: busy %b want 0", bus.busy);
    end
    st_hang = 0;
    m_prio  = 0;
  endtask

  task automatic test_reset_mid();
    logic [30:0] d, s;
    logic [130:0] outs;
    int sn, sc, ac;
    d = 31'($urandom); s = 31'($urandom) | 31'h1;
    st_lat = 10;
    bus.dvd0 = d; bus.dvs0 = s; bus.req0 = 1;
    sn = 0; sc = -1; ac = -1;
    for (int k = 1; k <= 40 && ac < 0; k++) begin
      step();
      if (k == 6) begin
        reset_n = 1'b0;
        #1;
        outs = {bus.ack0, bus.ack1, bus.ovf, bus.err, bus.busy, bus.owner, bus.div_start,
                bus.res, bus.div_dividend, bus.div_divisor, bus.ovf, bus.err, bus.busy};
        n_cmp++;
        if (outs !== '0) begin
          n_fail++;
          $display("FAIL resetmid_outputs: got %h want 0", outs);
        end
        m_prio = 1;
      end
      if (k == 9) begin
        reset_n = 1'b1;
        n_cmp++;
        if ({bus.div_start, bus.busy} !== 2'b00) begin
          n_fail++;
          $display("FAIL resetmid_idle: div_start/busy %b want 00", {bus.div_start, bus.busy});
        end
      end
      if (k > 6 && bus.div_start) begin
        sn++;
        if (sc < 0) sc = k;
      end
      if (k == 10) stray = 1;
      if (k == 20) begin
        n_cmp++;
        if (bus.res !== 31'h0 || bus.ovf !== 1'b0) begin
          n_fail++;
          $display("FAIL resetmid_stray: res %h ovf %b want 0/0", bus.res, bus.ovf);
        end
      end
      if (k > 6 && bus.ack0) begin
        ac = k;
        n_cmp++;
        if (bus.res !== quot(d, s) || bus.ovf !== dz(s) || bus.err !== 1'b0) begin
          n_fail++;
          $display("FAIL resetmid_res: res %h ovf %b want %h/%b", bus.res, bus.ovf, quot(d, s), dz(s));
        end
        bus.req0 = 0;
      end
    end
    n_cmp++;
    if (sc !== 10 || sn !== 1 || ac !== 21) begin
      n_fail++;
      $display("FAIL resetmid_timing: start %0d count %0d ack %0d want 10/1/21", sc, sn, ac);
    end
    m_prio = 0;
    step();
  endtask

  task automatic test_isolation();
    logic [30:0] d, s;
    int ac;
    d = 31'($urandom); s = 31'($urandom) | 31'h100;
    st_lat = 10;
    bus.dvd0 = d; bus.dvs0 = s; bus.req0 = 1;
    ac = -1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k <= 11) begin
        bus.dvd0 = 31'($urandom);
        bus.dvs0 = 31'($urandom);
        n_cmp++;
        if (bus.div_dividend !== d || bus.div_divisor !== s) begin
          n_fail++;
          $display("FAIL isolation_c%0d: dividend %h divisor %h want %h/%h",
                   k, bus.div_dividend, bus.div_divisor, d, s);
        end
      end
      if (bus.ack0) begin
        ac = k;
        bus.req0 = 0;
      end
    end
    n_cmp++;
    if (ac !== 12 || bus.res !== quot(d, s)) begin
      n_fail++;
      $display("FAIL isolation_res: ack %0d res %h want 12/%h", ac, bus.res, quot(d, s));
    end
    m_prio = 0;
    step();
  endtask

  task automatic test_random();
    int ac, a0, a1, sn, sc;
    logic [30:0] r;
    logic o, e, ow;
    for (int it = 0; it < 24; it++) begin
      logic [30:0] d [2];
      logic [30:0] s [2];
      int          order [$];
      int          lat, who, exp_cyc;
      logic [1:0]  rq;
      logic [32:0] exp_t;
      rq = 2'($urandom_range(1, 3));
      for (int i = 0; i < 2; i++) begin
        d[i] = 31'($urandom);
        s[i] = ($urandom_range(0, 4) == 0) ? 31'h0 : 31'($urandom);
      end
      lat = $urandom_range(2, 20);
      st_lat = lat;
      bus.dvd0 = d[0]; bus.dvs0 = s[0]; bus.dvd1 = d[1]; bus.dvs1 = s[1];
      bus.req0 = rq[0]; bus.req1 = rq[1];
      order = {};
      if (rq == 2'b11) begin
        order.push_back(m_prio == 1 ? 0 : 1);
        order.push_back(m_prio == 1 ? 1 : 0);
      end else begin
        order.push_back(rq[1] ? 1 : 0);
      end
      foreach (order[j]) begin
        who = order[j];
        exp_cyc = (lat <= TO + 1) ? lat + 2 : TO + 3;
        exp_t = (lat <= TO + 1) ? {quot(d[who], s[who]), dz(s[who]), 1'b0}
                                : {31'h0, 1'b1, 1'b1};
        serve(ac, a0, a1, sn, sc, r, o, e, ow);
        n_cmp++;
        if (ac !== exp_cyc || ow !== 1'(who) || a0 !== (who == 0 ? 1 : 0) || a1 !== (who == 1 ? 1 : 0)) begin
          n_fail++;
          $display("FAIL rand%0d_grant: cycle %0d owner %b ack0 %0d ack1 %0d want %0d/%0d",
                   it, ac, ow, a0, a1, exp_cyc, who);
        end
        n_cmp++;
        if ({r, o, e} !== exp_t) begin
          n_fail++;
          $display("FAIL rand%0d_result: got %h want %h (lat %0d)", it, {r, o, e}, exp_t, lat);
        end
        m_prio = who;
        step();
      end
    end
  endtask

  initial begin
    bus.req0 = 0; bus.req1 = 0;
    bus.dvd0 = '0; bus.dvd1 = '0; bus.dvs0 = '0; bus.dvs1 = '0;
    bus.div_stop = 0; bus.div_out = '0; bus.div_overflow = 0;
    test_reset();
    test_single();
    test_tie();
    test_divzero();
    test_watchdog();
    test_reset_mid();
    test_isolation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "time limit");
  end

endmodule
